// File: rtl/spi_slave_tx_pkg.sv
// Shared constants, FSM encodings and helpers for the SPI mode-0 slave serializer.
// FRAME_BYTES covers one frame of POINT_NUM two-byte samples.
package spi_slave_tx_pkg;

  localparam int DATA_W          = 8;
  localparam int POINT_NUM       = 400;
  localparam int FRAME_BYTES     = POINT_NUM * 2;
  localparam int CNT_W           = $clog2(FRAME_BYTES);
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOAD_LAT    = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } edge_t;

  function automatic logic [CNT_W-1:0] wrapInc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(FRAME_BYTES - 1)) ? '0 : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/spi_slave_tx_if.sv
// SPI pins towards the host plus the byte handshake towards the FIFO read stage.
interface spi_slave_tx_if;
  import spi_slave_tx_pkg::*;

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [DATA_W-1:0] spi_data;
  logic              byte_req;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_data,
    output spi_miso, spi_miso_oe, byte_req
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_data,
    input  spi_miso, spi_miso_oe, byte_req
  );

endinterface

// File: rtl/spi_slave_tx_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin followed by an edge register.
// RST_VAL is the pin's idle level so that leaving reset produces no spurious edge.
module spi_slave_tx_sync_edge
  import spi_slave_tx_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  pin_i,
  output edge_t edges_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              level;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      last_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign level   = sync_q[STAGES-1];
  assign edges_o = '{level: level, rise: level & ~last_q, fall: ~level & last_q};

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: fetches one byte per slot from the FIFO read stage
// and shifts it out MSB-first, counting bytes per frame and flagging late SCLK edges.
module spi_slave_tx
  import spi_slave_tx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOAD_LAT    = DEF_LOAD_LAT
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  spi_slave_tx_if.slave    spi,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic             frame_done_o,
  output logic             underrun_o
);

  localparam int LCNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int BCNT_W = $clog2(DATA_W);

  edge_t sclk;
  edge_t csn;
  logic  unusedLevels;

  logic [1:0]        state_q,     state_d;
  logic [LCNT_W-1:0] loadCnt_q,   loadCnt_d;
  logic [BCNT_W-1:0] bitCnt_q,    bitCnt_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0]  byteCnt_q,   byteCnt_d;
  logic              miso_q,      miso_d;
  logic              oe_q,        oe_d;
  logic              byteReq_q,   byteReq_d;
  logic              frameDone_q, frameDone_d;
  logic              underrun_q,  underrun_d;

  spi_slave_tx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclkSync (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .pin_i   (spi.spi_sclk),
    .edges_o (sclk)
  );

  spi_slave_tx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csSync (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .pin_i   (spi.spi_cs_n),
    .edges_o (csn)
  );

  // Only the strobes steer the FSM; synchronized levels are not needed here.
  assign unusedLevels = sclk.level ^ csn.level;

  always_comb begin
    state_d     = state_q;
    loadCnt_d   = loadCnt_q;
    bitCnt_d    = bitCnt_q;
    shreg_d     = shreg_q;
    byteCnt_d   = byteCnt_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    underrun_d  = underrun_q;
    byteReq_d   = 1'b0;
    frameDone_d = 1'b0;

    // CS deassertion aborts any partial byte; the frame position is kept.
    if (csn.rise) begin
      state_d  = ST_IDLE;
      oe_d     = 1'b0;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
          if (csn.fall) begin
            byteReq_d  = 1'b1;
            underrun_d = 1'b0;
            loadCnt_d  = '0;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (sclk.rise) underrun_d = 1'b1;
          if (loadCnt_q == LCNT_W'(LOAD_LAT - 1)) begin
            shreg_d  = spi.spi_data;
            miso_d   = spi.spi_data[DATA_W-1];
            oe_d     = 1'b1;
            bitCnt_d = '0;
            state_d  = ST_SHIFT;
          end else begin
            loadCnt_d = loadCnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sclk.rise) begin
            if (bitCnt_q == BCNT_W'(DATA_W - 1)) begin
              byteCnt_d   = wrapInc(byteCnt_q);
              frameDone_d = (byteCnt_q == CNT_W'(FRAME_BYTES - 1));
              byteReq_d   = 1'b1;
              bitCnt_d    = '0;
              loadCnt_d   = '0;
              state_d     = ST_FETCH;
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end else if (sclk.fall && bitCnt_q != '0) begin
            shreg_d = shreg_q << 1;
            miso_d  = shreg_q[DATA_W-2];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= ST_IDLE;
      loadCnt_q   <= '0;
      bitCnt_q    <= '0;
      shreg_q     <= '0;
      byteCnt_q   <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      byteReq_q   <= 1'b0;
      frameDone_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      loadCnt_q   <= loadCnt_d;
      bitCnt_q    <= bitCnt_d;
      shreg_q     <= shreg_d;
      byteCnt_q   <= byteCnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      byteReq_q   <= byteReq_d;
      frameDone_q <= frameDone_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign spi.byte_req    = byteReq_q;
  assign byte_cnt_o      = byteCnt_q;
  assign frame_done_o    = frameDone_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a host SPI model and a FIFO model feed the DUT, and a
// byte-level reference (queues of supplied bytes, frame counter) predicts its outputs.
module tb_spi_slave_tx;
  import spi_slave_tx_pkg::*;

  localparam int HALF_SLOW = 8;
  localparam int HALF_FAST = 4;
  localparam int CS_SETUP  = DEF_SYNC_STAGES + DEF_LOAD_LAT + 6;
  localparam int SETTLE    = DEF_SYNC_STAGES + DEF_LOAD_LAT + 2;

  logic             sysClk = 1'b0;
  logic             sysRst;
  logic [CNT_W-1:0] byteCnt;
  logic             frameDone;
  logic             underrun;

  int nCompared   = 0;
  int nMismatched = 0;
  int reqCnt      = 0;
  int frameCnt    = 0;
  int expByteCnt  = 0;

  logic [7:0] srcQ[$];
  logic [7:0] inflightQ[$];

  spi_slave_tx_if spiBus();

  spi_slave_tx dut (
    .sys_clk_i    (sysClk),
    .sys_rst_i    (sysRst),
    .spi          (spiBus),
    .byte_cnt_o   (byteCnt),
    .frame_done_o (frameDone),
    .underrun_o   (underrun)
  );

  always #5 sysClk = ~sysClk;

  // One system cycle; also plays the FIFO that answers each byte request.
  task automatic tick();
    logic [7:0] b;
    @(negedge sysClk);
    if (spiBus.byte_req === 1'b1) begin
      b = (srcQ.size() > 0) ? srcQ.pop_front() : 8'($urandom);
      spiBus.spi_data = b;
      inflightQ.push_back(b);
      reqCnt++;
    end
    if (frameDone === 1'b1) frameCnt++;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic shiftBits(input int half, input int bits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < bits; i++) begin
      rx = {rx[6:0], spiBus.spi_miso};
      spiBus.spi_sclk = 1'b1;
      waitCycles(half);
      spiBus.spi_sclk = 1'b0;
      waitCycles(half);
    end
  endtask

  task automatic hostByte(input int half, output logic [7:0] rx, output logic [7:0] exp);
    shiftBits(half, 8, rx);
    exp = (inflightQ.size() > 0) ? inflightQ.pop_front() : 8'hxx;
    expByteCnt = (expByteCnt + 1) % FRAME_BYTES;
  endtask

  task automatic csDrop();
    spiBus.spi_cs_n = 1'b0;
    waitCycles(CS_SETUP);
  endtask

  task automatic csRaise();
    spiBus.spi_sclk = 1'b0;
    spiBus.spi_cs_n = 1'b1;
    waitCycles(SETTLE);
    inflightQ.delete();
  endtask

  task automatic test_reset();
    bit sawActivity;
    sysRst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      spiBus.spi_sclk = 1'($urandom);
      spiBus.spi_cs_n = 1'($urandom);
      spiBus.spi_data = 8'($urandom);
      tick();
    end
    nCompared++;
    if (spiBus.byte_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_byte_req: got %b expected 0", spiBus.byte_req); end
    nCompared++;
    if (spiBus.spi_miso !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_miso: got %b expected 0", spiBus.spi_miso); end
    nCompared++;
    if (spiBus.spi_miso_oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_oe: got %b expected 0", spiBus.spi_miso_oe); end
    nCompared++;
    if (byteCnt !== '0) begin nMismatched++; $display("[TB] FAIL reset_byte_cnt: got %0d expected 0", byteCnt); end
    nCompared++;
    if ({frameDone, underrun} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b expected 00", {frameDone, underrun}); end
    spiBus.spi_sclk = 1'b0;
    spiBus.spi_cs_n = 1'b1;
    waitCycles(2);
    sysRst = 1'b0;
    sawActivity = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (spiBus.byte_req !== 1'b0 || spiBus.spi_miso_oe !== 1'b0) sawActivity = 1'b1;
    end
    nCompared++;
    if (sawActivity !== 1'b0) begin nMismatched++; $display("[TB] FAIL release_idle: got activity=%b expected 0", sawActivity); end
    reqCnt = 0; frameCnt = 0; expByteCnt = 0;
    inflightQ.delete();
  endtask

  task automatic test_single_byte();
    logic [7:0] rx, exp;
    srcQ.push_back(8'hA5);
    reqCnt = 0;
    csDrop();
    hostByte(HALF_SLOW, rx, exp);
    waitCycles(SETTLE);
    nCompared++;
    if (rx !== exp) begin nMismatched++; $display("[TB] FAIL single_model: got %h expected %h", rx, exp); end
    nCompared++;
    if (rx !== 8'hA5) begin nMismatched++; $display("[TB] FAIL single_a5: got %h expected a5", rx); end
    nCompared++;
    if (reqCnt !== 2) begin nMismatched++; $display("[TB] FAIL single_req_count: got %0d expected 2", reqCnt); end
    nCompared++;
    if (byteCnt !== CNT_W'(expByteCnt)) begin nMismatched++; $display("[TB] FAIL single_byte_cnt: got %0d expected %0d", byteCnt, expByteCnt); end
    csRaise();
  endtask

  task automatic test_frame();
    logic [7:0] rx, exp;
    sysRst = 1'b1;
    tick();
    sysRst = 1'b0;
    tick();
    expByteCnt = 0; frameCnt = 0;
    srcQ.delete();
    for (int i = 0; i < FRAME_BYTES; i++) srcQ.push_back(8'(i));
    csDrop();
    for (int i = 0; i < FRAME_BYTES; i++) begin
      hostByte(HALF_FAST, rx, exp);
      nCompared++;
      if (rx !== exp || rx !== 8'(i)) begin nMismatched++; $display("[TB] FAIL frame_byte_%0d: got %h expected %h", i, rx, 8'(i)); end
      if (i == FRAME_BYTES - 2) begin
        nCompared++;
        if (frameCnt !== 0) begin nMismatched++; $display("[TB] FAIL frame_done_early: got %0d pulses expected 0", frameCnt); end
      end
    end
    waitCycles(SETTLE);
    nCompared++;
    if (frameCnt !== 1) begin nMismatched++; $display("[TB] FAIL frame_done_count: got %0d expected 1", frameCnt); end
    nCompared++;
    if (byteCnt !== CNT_W'(expByteCnt)) begin nMismatched++; $display("[TB] FAIL frame_wrap_cnt: got %0d expected %0d", byteCnt, expByteCnt); end
    nCompared++;
    if (underrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL frame_underrun: got %b expected 0", underrun); end
    csRaise();
  endtask

  task automatic test_abort();
    logic [7:0] rx, exp, newByte;
    int reqBefore;
    csDrop();
    shiftBits(HALF_SLOW, 3, rx);
    nCompared++;
    if (spiBus.spi_miso_oe !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_oe_active: got %b expected 1", spiBus.spi_miso_oe); end
    spiBus.spi_cs_n = 1'b1;
    waitCycles(DEF_SYNC_STAGES + 1);
    nCompared++;
    if (spiBus.spi_miso_oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_oe_off: got %b expected 0", spiBus.spi_miso_oe); end
    waitCycles(SETTLE);
    nCompared++;
    if (byteCnt !== CNT_W'(expByteCnt)) begin nMismatched++; $display("[TB] FAIL abort_byte_cnt: got %0d expected %0d", byteCnt, expByteCnt); end
    inflightQ.delete();
    newByte = 8'($urandom);
    srcQ.push_back(newByte);
    reqBefore = reqCnt;
    csDrop();
    nCompared++;
    if (reqCnt !== reqBefore + 1) begin nMismatched++; $display("[TB] FAIL abort_new_req: got %0d expected %0d", reqCnt, reqBefore + 1); end
    hostByte(HALF_SLOW, rx, exp);
    waitCycles(SETTLE);
    nCompared++;
    if (rx !== exp || rx !== newByte) begin nMismatched++; $display("[TB] FAIL abort_new_byte: got %h expected %h", rx, newByte); end
    nCompared++;
    if (byteCnt !== CNT_W'(expByteCnt)) begin nMismatched++; $display("[TB] FAIL abort_after_cnt: got %0d expected %0d", byteCnt, expByteCnt); end
    csRaise();
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    csDrop();
    nCompared++;
    if (underrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL underrun_initial: got %b expected 0", underrun); end
    shiftBits(HALF_FAST, 7, rx);
    spiBus.spi_sclk = 1'b1;
    tick();
    spiBus.spi_sclk = 1'b0;
    tick();
    spiBus.spi_sclk = 1'b1;
    expByteCnt = (expByteCnt + 1) % FRAME_BYTES;
    waitCycles(SETTLE + 2);
    nCompared++;
    if (underrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL underrun_set: got %b expected 1", underrun); end
    spiBus.spi_sclk = 1'b0;
    waitCycles(4);
    spiBus.spi_cs_n = 1'b1;
    waitCycles(SETTLE);
    nCompared++;
    if (underrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL underrun_sticky: got %b expected 1", underrun); end
    inflightQ.delete();
    csDrop();
    nCompared++;
    if (underrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL underrun_clear: got %b expected 0", underrun); end
    nCompared++;
    if (byteCnt !== CNT_W'(expByteCnt)) begin nMismatched++; $display("[TB] FAIL underrun_byte_cnt: got %0d expected %0d", byteCnt, expByteCnt); end
    csRaise();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, exp;
    csDrop();
    for (int i = 0; i < 10; i++) begin
      hostByte(HALF_FAST, rx, exp);
      nCompared++;
      if (rx !== exp) begin nMismatched++; $display("[TB] FAIL midrst_byte_%0d: got %h expected %h", i, rx, exp); end
    end
    shiftBits(HALF_FAST, 5, rx);
    nCompared++;
    if ({spiBus.spi_miso_oe, byteCnt} !== {1'b1, CNT_W'(expByteCnt)}) begin
      nMismatched++; $display("[TB] FAIL midrst_before: got oe=%b cnt=%0d expected oe=1 cnt=%0d", spiBus.spi_miso_oe, byteCnt, expByteCnt);
    end
    @(posedge sysClk);
    #3 sysRst = 1'b1;
    #1;
    nCompared++;
    if ({spiBus.spi_miso_oe, spiBus.spi_miso, spiBus.byte_req, frameDone, underrun, byteCnt} !== '0) begin
      nMismatched++; $display("[TB] FAIL midrst_async: got oe=%b miso=%b req=%b fd=%b ur=%b cnt=%0d expected all 0",
        spiBus.spi_miso_oe, spiBus.spi_miso, spiBus.byte_req, frameDone, underrun, byteCnt);
    end
    spiBus.spi_cs_n = 1'b1;
    spiBus.spi_sclk = 1'b0;
    waitCycles(3);
    sysRst = 1'b0;
    expByteCnt = 0;
    reqCnt = 0;
    inflightQ.delete();
    waitCycles(4);
    nCompared++;
    if (reqCnt !== 0) begin nMismatched++; $display("[TB] FAIL midrst_no_req: got %0d expected 0", reqCnt); end
    csDrop();
    hostByte(HALF_SLOW, rx, exp);
    waitCycles(SETTLE);
    nCompared++;
    if (rx !== exp) begin nMismatched++; $display("[TB] FAIL midrst_restart_byte: got %h expected %h", rx, exp); end
    nCompared++;
    if (byteCnt !== CNT_W'(expByteCnt)) begin nMismatched++; $display("[TB] FAIL midrst_restart_cnt: got %0d expected %0d", byteCnt, expByteCnt); end
    csRaise();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sysRst          = 1'b1;
    spiBus.spi_sclk = 1'b0;
    spiBus.spi_cs_n = 1'b1;
    spiBus.spi_data = '0;
    $display("[TB] starting spi_slave_tx bench");
    test_reset();
    test_single_byte();
    test_frame();
    test_abort();
    test_underrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
